fifo_write_ctrl_param: RTL

//  Parametrised write-side controller for a single-clock FIFO. It gates the

---
 rtl/fifo_write_ctrl_param_if.sv | 46 ++++
 rtl/fifo_write_ctrl_param.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_write_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// fifo_write_ctrl_param_if
// Bundles the producer / read-side handshake of the FIFO write controller.
//   i_wen       producer write request
//   i_ren_done  read controller popped one entry this cycle
//   i_flush     synchronous clear of pointer and occupancy
//   i_err_clr   synchronous clear of sticky error flags
//   o_wen_ctrl  gated write enable to the FIFO RAM
//   o_waddr     RAM write address
//   o_wptr      write pointer including wrap bit
//   o_count     occupancy, 0..DEPTH
//   o_full      registered full flag
//   o_afull     registered almost-full flag
//   o_ovf       sticky overflow flag
//   o_udf       sticky underflow flag
// master: drives the requests (producer / environment side)
// slave : the write controller itself
// ---------------------------------------------------------------------------
interface fifo_write_ctrl_param_if #(
    parameter int ADDR_W = 4
);
    logic              i_wen;
    logic              i_ren_done;
    logic              i_flush;
    logic              i_err_clr;
    logic              o_wen_ctrl;
    logic [ADDR_W-1:0] o_waddr;
    logic [ADDR_W:0]   o_wptr;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_afull;
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output i_wen, i_ren_done, i_flush, i_err_clr,
        input  o_wen_ctrl, o_waddr, o_wptr, o_count,
               o_full, o_afull, o_ovf, o_udf
    );

    modport slave (
        input  i_wen, i_ren_done, i_flush, i_err_clr,
        output o_wen_ctrl, o_waddr, o_wptr, o_count,
               o_full, o_afull, o_ovf, o_udf
    );
endinterface

// File: rtl/fifo_write_ctrl_param.sv
// ---------------------------------------------------------------------------
// fifo_write_ctrl_param
// Write-side controller of a single-clock FIFO. Gates producer writes against
// the registered full flag, generates the RAM write address and the wrapped
// write pointer, tracks occupancy from accepted writes and read-side pops and
// raises almost-full plus sticky overflow / underflow flags.
// Ports:
//   i_clk   clock, all state updates on the rising edge
//   i_rest  asynchronous, active-low reset
//   bus     fifo_write_ctrl_param_if.slave (requests in, status out)
// Parameters:
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   AFULL_TH  occupancy at or above which o_afull asserts (1..DEPTH)
// ---------------------------------------------------------------------------
module fifo_write_ctrl_param #(
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = (1 << ADDR_W) - 2
) (
    input  logic                          i_clk,
    input  logic                          i_rest,
    fifo_write_ctrl_param_if.slave        bus
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_C = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wptr_q,  wptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            full_q,  full_d;
    logic            afull_q, afull_d;
    logic            ovf_q,   ovf_d;
    logic            udf_q,   udf_d;
    logic            wenOk;
    logic            popOk;
    logic            ovfSet;
    logic            udfSet;

    // Write acceptance is combinational so the RAM writes on the same edge
    // that advances the pointer. Full is the registered flag, so a write in
    // the same cycle as a pop from a full FIFO is still refused. The reset
    // term keeps the RAM from being written while reset is held.
    assign wenOk = i_rest & bus.i_wen & ~full_q & ~bus.i_flush;

    // Next-state logic. Flush overrides writes and pops but leaves the sticky
    // error flags alone; an error set in the same cycle as a clear wins.
    always_comb begin
        popOk   = bus.i_ren_done & (count_q != '0);
        ovfSet  = bus.i_wen & full_q & ~bus.i_flush;
        udfSet  = bus.i_ren_done & (count_q == '0) & ~bus.i_flush;
        wptr_d  = wptr_q;
        count_d = count_q;

        if (bus.i_flush) begin
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (wenOk) begin
                wptr_d = wptr_q + ONE_C;
            end
            case ({wenOk, popOk})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);
        ovf_d   = (ovf_q & ~bus.i_err_clr) | ovfSet;
        udf_d   = (udf_q & ~bus.i_err_clr) | udfSet;
    end

    // State registers; everything clears asynchronously on reset.
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            wptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign bus.o_wen_ctrl = wenOk;
    assign bus.o_waddr    = wptr_q[ADDR_W-1:0];
    assign bus.o_wptr     = wptr_q;
    assign bus.o_count    = count_q;
    assign bus.o_full     = full_q;
    assign bus.o_afull    = afull_q;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_udf      = udf_q;

endmodule
